// File: rtl/dds_phase_accumulator.sv
// Phase accumulator (NCO) feeding the sine-table DDS stage, with FTW handshake and linear glide.
// Optional output dither on the phase word is compiled in with `define DDS_DITHER_EN.
module dds_phase_accumulator #(
  parameter int unsigned      ACC_W       = 32,
  parameter int unsigned      GLIDE_W     = 16,
  parameter logic [ACC_W-1:0] FTW_RESET   = '0,
  parameter logic [ACC_W-1:0] PHASE_RESET = '0,
  parameter int unsigned      DITHER_BITS = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               SAMPLE_EN,
  input  logic [ACC_W-1:0]   FTW_IN,
  input  logic               FTW_VALID,
  output logic               FTW_READY,
  input  logic [GLIDE_W-1:0] GLIDE_RATE,
  input  logic               PHASE_SYNC,
  output logic [ACC_W-1:0]   DDS_OUT,
  output logic               WRAP,
  output logic               GLIDING
);

  typedef enum logic {ST_STEADY, ST_GLIDE} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_phase;
  logic [ACC_W-1:0] r_cur_ftw;
  logic [ACC_W-1:0] r_target;
  logic [ACC_W-1:0] r_rate_q;
  logic             r_wrap;

  logic             w_hs;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_phase_nxt;
  logic [ACC_W-1:0] w_glide_nxt;

  if (DITHER_BITS < 1 || DITHER_BITS > 16) begin : g_bad_dither
    $error("DITHER_BITS must be in 1..16");
  end

  assign w_hs  = FTW_VALID && (r_state == ST_STEADY);
  assign w_sum = {1'b0, r_phase} + {1'b0, r_cur_ftw};

  always_comb begin
    w_phase_nxt = r_phase;
    if (PHASE_SYNC)
      w_phase_nxt = PHASE_RESET;
    else if (SAMPLE_EN)
      w_phase_nxt = w_sum[ACC_W-1:0];
  end

  // Distance is compared before stepping so the glide lands exactly on target without wrapping.
  always_comb begin
    w_glide_nxt = r_target;
    if (r_target > r_cur_ftw) begin
      if (r_target - r_cur_ftw > r_rate_q)
        w_glide_nxt = r_cur_ftw + r_rate_q;
    end else begin
      if (r_cur_ftw - r_target > r_rate_q)
        w_glide_nxt = r_cur_ftw - r_rate_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_STEADY;
      r_phase   <= PHASE_RESET;
      r_cur_ftw <= FTW_RESET;
      r_target  <= FTW_RESET;
      r_rate_q  <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_wrap  <= !PHASE_SYNC && SAMPLE_EN && w_sum[ACC_W];
      case (r_state)
        ST_STEADY: begin
          if (w_hs) begin
            r_target <= FTW_IN;
            r_rate_q <= ACC_W'(GLIDE_RATE);
            if (GLIDE_RATE == '0)
              r_cur_ftw <= FTW_IN;
            else if (FTW_IN != r_cur_ftw)
              r_state <= ST_GLIDE;
          end
        end
        ST_GLIDE: begin
          if (SAMPLE_EN) begin
            r_cur_ftw <= w_glide_nxt;
            if (w_glide_nxt == r_target)
              r_state <= ST_STEADY;
          end
        end
        default: r_state <= ST_STEADY;
      endcase
    end
  end

  assign FTW_READY = (r_state == ST_STEADY);
  assign GLIDING   = (r_state == ST_GLIDE);
  assign WRAP      = r_wrap;

`ifdef DDS_DITHER_EN
  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_nxt;
  logic [ACC_W-1:0] r_dds;

  assign w_lfsr_nxt = SAMPLE_EN ? {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]}
                                : r_lfsr;

  // Dither is added on the output path only; the accumulator and WRAP stay undithered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_lfsr <= 16'hACE1;
      r_dds  <= PHASE_RESET;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      r_dds  <= w_phase_nxt + ACC_W'(w_lfsr_nxt[DITHER_BITS-1:0]);
    end
  end

  assign DDS_OUT = r_dds;
`else
  assign DDS_OUT = r_phase;
`endif

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Self-checking bench for dds_phase_accumulator: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_dds_phase_accumulator;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        SAMPLE_EN;
  logic [31:0] FTW_IN;
  logic        FTW_VALID;
  logic        FTW_READY;
  logic [15:0] GLIDE_RATE;
  logic        PHASE_SYNC;
  logic [31:0] DDS_OUT;
  logic        WRAP;
  logic        GLIDING;

  int n_checks = 0;
  int n_pass   = 0;

  localparam longint unsigned MOD = 64'h1_0000_0000;

  longint unsigned m_phase, m_cur, m_target, m_rate, m_dds;
  bit              m_glide, m_wrap;
  bit [15:0]       m_lfsr;

  always #5 CLK = ~CLK;

  dds_phase_accumulator #(
    .ACC_W       (32),
    .GLIDE_W     (16),
    .FTW_RESET   (32'h0),
    .PHASE_RESET (32'h0),
    .DITHER_BITS (8)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SAMPLE_EN  (SAMPLE_EN),
    .FTW_IN     (FTW_IN),
    .FTW_VALID  (FTW_VALID),
    .FTW_READY  (FTW_READY),
    .GLIDE_RATE (GLIDE_RATE),
    .PHASE_SYNC (PHASE_SYNC),
    .DDS_OUT    (DDS_OUT),
    .WRAP       (WRAP),
    .GLIDING    (GLIDING)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_cur = 0; m_target = 0; m_rate = 0; m_dds = 0;
    m_glide = 0; m_wrap = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_dds"},   DDS_OUT,   m_dds);
    check({tag, "_wrap"},  WRAP,      m_wrap);
    check({tag, "_glide"}, GLIDING,   m_glide);
    check({tag, "_ready"}, FTW_READY, !m_glide);
  endtask

  task automatic step(input bit se, ps, v, input bit [31:0] f, input bit [15:0] gr);
    longint unsigned t;
    bit hs;
    SAMPLE_EN = se; PHASE_SYNC = ps; FTW_VALID = v; FTW_IN = f; GLIDE_RATE = gr;
    hs = v && !m_glide;
    if (ps) begin
      m_phase = 0; m_wrap = 0;
    end else if (se) begin
      t = m_phase + m_cur;
      m_wrap  = (t >= MOD);
      m_phase = t % MOD;
    end else begin
      m_wrap = 0;
    end
    if (hs) begin
      m_target = f; m_rate = gr;
      if (gr == 0) m_cur = f;
      else if (f != m_cur) m_glide = 1;
    end else if (m_glide && se) begin
      if (m_target > m_cur) m_cur = (m_cur + m_rate >= m_target) ? m_target : m_cur + m_rate;
      else                  m_cur = (m_cur <= m_target + m_rate) ? m_target : m_cur - m_rate;
      if (m_cur == m_target) m_glide = 0;
    end
`ifdef DDS_DITHER_EN
    if (se) m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    m_dds = (m_phase + longint'(m_lfsr[7:0])) % MOD;
`else
    m_dds = m_phase;
`endif
    @(posedge CLK); #1;
    check_outputs("step");
  endtask

  task automatic do_reset();
    SAMPLE_EN = 0; PHASE_SYNC = 0; FTW_VALID = 0; FTW_IN = '0; GLIDE_RATE = '0;
    RESET = 1'b0;
    #2;
    model_reset();
    check_outputs("rst");
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check_outputs("rst_rel");
    step(0, 0, 0, 0, 0);
    check_outputs("rst_hold");
  endtask

  initial begin
    logic [31:0] exp_dds [5];
    bit   [3:0]  exp_gl3;
    bit   [3:0]  exp_gl4;
    bit   [31:0] f;
    bit   [15:0] gr;
    int          guard;

    exp_dds = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000, 32'h4000_0000};
    exp_gl3 = 4'b0011;
    exp_gl4 = 4'b0111;
    RESET = 1'b1;
    SAMPLE_EN = 0; PHASE_SYNC = 0; FTW_VALID = 0; FTW_IN = '0; GLIDE_RATE = '0;
    #1;
    do_reset();

    step(0, 0, 1, 32'h4000_0000, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0);
`ifndef DDS_DITHER_EN
      check("load_dds", DDS_OUT, exp_dds[i]);
`endif
      check("load_wrap", WRAP, (i == 3));
    end

    step(0, 0, 1, 100, 0);
    step(0, 0, 1, 350, 100);
    check("glide_up_start", GLIDING, 1);
    check("glide_up_ready", FTW_READY, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      check("glide_up_flag", GLIDING, exp_gl3[i]);
    end
    step(0, 0, 1, 0, 100);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      check("glide_dn_flag", GLIDING, exp_gl4[i]);
    end

    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFF0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h20, 0);
    step(1, 1, 0, 0, 0);
`ifndef DDS_DITHER_EN
    check("sync_dds", DDS_OUT, 0);
`endif
    check("sync_wrap", WRAP, 0);

    step(0, 0, 1, 1000, 300);
    guard = 0;
    while (m_glide && guard < 20) begin
      step(1, 0, 1, 5000, 0);
      guard++;
    end
    check("bp_glide_ended", guard < 20, 1);
    step(1, 0, 1, 5000, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if ($urandom % 4 == 0) begin
        f  = $urandom;
        gr = 0;
      end else begin
        f  = 32'(m_cur) + $urandom_range(0, 40000) - 20000;
        gr = ($urandom % 3 == 0) ? 16'd0 : 16'($urandom_range(1, 6000));
      end
      step(($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 3) == 0, f, gr);
    end

`ifdef DDS_DITHER_EN
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0);
      check("dith_hi", DDS_OUT[31:8], 0);
      check("dith_wrap", WRAP, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
